// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter and branch-resolution controller.
// Takes the selected condition flag from the flag multiplexer, resolves
// conditional and unconditional branches coming from decode, and steers the PC.
// A taken branch produces a one-cycle flush pulse and a programmable fetch
// bubble before fetching resumes at the target.
// Optional build feature: define PC_BRANCH_STATS_EN to add saturating
// taken / not-taken resolution counters (taken_cnt_o, nottaken_cnt_o).

module pc_branch_ctrl #(
  parameter int                PC_W         = 32,
  parameter logic [PC_W-1:0]   RESET_PC     = {PC_W{1'b0}},
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_valid_i,
  input  logic            br_uncond_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            flag_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            br_taken_o,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]     taken_cnt_o,
  output logic [15:0]     nottaken_cnt_o,
`endif
  output logic            busy_o
);

  // Counter only ever holds values 0 .. FLUSH_CYCLES-1.
  localparam int              CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
  // Targets are forced word-aligned; misaligned low bits are dropped silently.
  localparam logic [PC_W-1:0]  ALIGN_MSK = {{(PC_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             br_taken_q, br_taken_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  logic             uncond_q, uncond_d;

  logic             taken_s;

  // Branch outcome uses the flag present in the resolving cycle only.
  assign taken_s = uncond_q | flag_i;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      br_taken_q    <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
      tgt_q         <= {PC_W{1'b0}};
      uncond_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      br_taken_q    <= br_taken_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      tgt_q         <= tgt_d;
      uncond_q      <= uncond_d;
    end
  end

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (!stall_i && br_valid_i) begin
          state_d = ST_RESOLVE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_RESOLVE: begin
        if (stall_i) begin
          state_d = ST_RESOLVE;
        end else if (taken_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Next values for the registered outputs, counter and latched branch info.
  always_comb begin
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    br_taken_d    = 1'b0;
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    uncond_d      = uncond_q;
    case (state_q)
      ST_FETCH: begin
        if (stall_i) begin
          pc_d = pc_q;
        end else if (br_valid_i) begin
          tgt_d         = br_target_i & ALIGN_MSK;
          uncond_d      = br_uncond_i;
          fetch_valid_d = 1'b0;
          busy_d        = 1'b1;
        end else begin
          pc_d          = pc_q + PC_STEP;
          fetch_valid_d = 1'b1;
        end
      end
      ST_RESOLVE: begin
        if (stall_i) begin
          pc_d = pc_q;
        end else if (taken_s) begin
          pc_d          = tgt_q;
          flush_d       = 1'b1;
          br_taken_d    = 1'b1;
          cnt_d         = CNT_INIT;
          fetch_valid_d = 1'b0;
        end else begin
          pc_d          = pc_q + PC_STEP;
          fetch_valid_d = 1'b1;
          busy_d        = 1'b0;
        end
      end
      ST_FLUSH: begin
        // stall is deliberately ignored while the bubble drains.
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d         = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          fetch_valid_d = 1'b0;
        end else begin
          fetch_valid_d = 1'b1;
          busy_d        = 1'b0;
        end
      end
      default: begin
        pc_d          = pc_q + PC_STEP;
        fetch_valid_d = 1'b1;
        busy_d        = 1'b0;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flush_q;
  assign br_taken_o    = br_taken_q;
  assign busy_o        = busy_q;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;
  logic [15:0] nottaken_cnt_q;
  logic        resolve_s;

  assign resolve_s = (state_q == ST_RESOLVE) && !stall_i;

  // Saturating resolution counters, one per outcome.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taken_cnt_q    <= 16'h0000;
      nottaken_cnt_q <= 16'h0000;
    end else if (resolve_s) begin
      if (taken_s) begin
        if (taken_cnt_q != 16'hFFFF) begin
          taken_cnt_q <= taken_cnt_q + 16'h0001;
        end
      end else begin
        if (nottaken_cnt_q != 16'hFFFF) begin
          nottaken_cnt_q <= nottaken_cnt_q + 16'h0001;
        end
      end
    end
  end

  assign taken_cnt_o    = taken_cnt_q;
  assign nottaken_cnt_o = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed testbench for pc_branch_ctrl (PC_W=32, RESET_PC=0, FLUSH_CYCLES=2).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.

module tb_pc_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_uncond;
  logic [31:0] br_target;
  logic        flag;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        br_taken;
  logic        busy;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pc_branch_ctrl #(
    .PC_W        (32),
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .br_valid_i   (br_valid),
    .br_uncond_i  (br_uncond),
    .br_target_i  (br_target),
    .flag_i       (flag),
    .pc_o         (pc),
    .fetch_valid_o(fetch_valid),
    .flush_o      (flush),
    .br_taken_o   (br_taken),
`ifdef PC_BRANCH_STATS_EN
    .taken_cnt_o   (taken_cnt),
    .nottaken_cnt_o(nottaken_cnt),
`endif
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_fv,
                         input logic e_fl, input logic e_bt, input logic e_busy);
    chk({tag, ".pc"},    pc,                   e_pc);
    chk({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".flush"}, {31'd0, flush},       {31'd0, e_fl});
    chk({tag, ".taken"}, {31'd0, br_taken},    {31'd0, e_bt});
    chk({tag, ".busy"},  {31'd0, busy},        {31'd0, e_busy});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_uncond = 1'b0;
    br_target = 32'h0; flag = 1'b0;
    step(); step();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sequential run after reset release.
    rst = 1'b0;
    step(); chk_all("run1", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("run2", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("run3", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("run4", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Conditional branch, flag=0: not taken.
    br_valid = 1'b1; br_uncond = 1'b0; br_target = 32'h80;
    step(); chk_all("nt_acc", 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    br_valid = 1'b0; flag = 1'b0;
    step(); chk_all("nt_res", 32'h14, 1'b1, 1'b0, 1'b0, 1'b0);

    // Conditional branch, flag=1: taken with 2-cycle bubble.
    br_valid = 1'b1; br_uncond = 1'b0; br_target = 32'h80;
    step(); chk_all("tk_acc", 32'h14, 1'b0, 1'b0, 1'b0, 1'b1);
    br_valid = 1'b0; flag = 1'b1;
    step(); chk_all("tk_res", 32'h80, 1'b0, 1'b1, 1'b1, 1'b1);
    flag = 1'b0;
    step(); chk_all("tk_fl1", 32'h80, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("tk_fl2", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("tk_next", 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);

    // Unconditional branch with misaligned target.
    br_valid = 1'b1; br_uncond = 1'b1; br_target = 32'h43;
    step(); chk_all("un_acc", 32'h84, 1'b0, 1'b0, 1'b0, 1'b1);
    br_valid = 1'b0; br_uncond = 1'b0; flag = 1'b0;
    step(); chk_all("un_res", 32'h40, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    step(); chk_all("un_done", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall in RESOLVE while flag toggles; final flag=1 decides.
    br_valid = 1'b1; br_uncond = 1'b0; br_target = 32'h100;
    step();
    br_valid = 1'b0; stall = 1'b1; flag = 1'b1;
    step(); chk_all("st_h1", 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    flag = 1'b0;
    step(); chk_all("st_h2", 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    flag = 1'b1;
    step(); chk_all("st_h3", 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    stall = 1'b0; flag = 1'b1;
    step(); chk_all("st_res", 32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
    // stall is ignored during the bubble.
    stall = 1'b1; flag = 1'b0;
    step(); chk_all("st_fl1", 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("st_fl2", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);

    // FETCH with stall: br_valid ignored, everything holds.
    br_valid = 1'b1; br_target = 32'h200;
    step(); chk_all("fs_hold", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b0; br_valid = 1'b0;
    step(); chk_all("fs_go", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall with flag=1, release with flag=0: not taken.
    br_valid = 1'b1; br_uncond = 1'b0; br_target = 32'h200;
    step();
    br_valid = 1'b0; stall = 1'b1; flag = 1'b1;
    step(); chk_all("sn_h", 32'h104, 1'b0, 1'b0, 1'b0, 1'b1);
    stall = 1'b0; flag = 1'b0;
    step(); chk_all("sn_res", 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset asserted in FLUSH aborts the branch.
    br_valid = 1'b1; br_uncond = 1'b1; br_target = 32'h300;
    step();
    br_valid = 1'b0; br_uncond = 1'b0;
    step(); chk_all("rf_res", 32'h300, 1'b0, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step(); chk_all("rf_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_all("rf_run", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_all("rf_run2", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);

    // Branch to top word; br_valid in RESOLVE/FLUSH must not re-latch.
    br_valid = 1'b1; br_uncond = 1'b1; br_target = 32'hFFFF_FFFE;
    step();
    br_uncond = 1'b0; br_target = 32'h500;
    step(); chk_all("wr_res", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); chk_all("wr_fl1", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("wr_fl2", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    br_valid = 1'b0;
    step(); chk_all("wr_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
Program-counter and branch-resolution controller that sits directly downstream of the processor's condition-flag multiplexer. It consumes the single selected `flag` bit, resolves conditional and unconditional branches from decode, and updates the PC. On a taken branch it issues a flush pulse and inserts a programmable fetch bubble.

Parameters:
PC_W, 32, width of the program counter in bits
RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)
FLUSH_CYCLES, 2, bubble cycles after a taken branch (must be >= 1)

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  freeze request from the pipeline; honoured in FETCH and RESOLVE only
br_valid  in  1  branch request from decode; sampled only in FETCH with stall=0
br_uncond  in  1  branch is unconditional; qualified by br_valid
br_target  in  PC_W  branch target address; qualified by br_valid
flag  in  1  selected condition flag from the flag mux; sampled in RESOLVE
pc  out  PC_W  current fetch address (registered)
fetch_valid  out  1  pc is a valid fetch address this cycle (registered)
flush  out  1  one-cycle pulse: discard younger in-flight instructions
br_taken  out  1  one-cycle pulse: last resolved branch was taken
busy  out  1  high while a branch is pending or a flush is in progress; decode holds br_valid

Behaviour:
- Interface decision: one clock `clk`. Reset `rst` is synchronous and active-high. No asynchronous paths.
- Reset state and outputs: state=FETCH, pc=RESET_PC, fetch_valid=0, flush=0, br_taken=0, busy=0, flush counter=0, latched target/uncond=0.
- First cycle after rst deasserts: fetch_valid=1.
- States: FETCH, RESOLVE, FLUSH.
- FETCH, stall=1:
  - All registers hold. fetch_valid holds its value.
  - br_valid is ignored and not latched.
- FETCH, stall=0, br_valid=0:
  - pc <= pc+4, wrapping modulo 2^PC_W.
  - fetch_valid <= 1.
- FETCH, stall=0, br_valid=1:
  - Latch target = {br_target[PC_W-1:2], 2'b00}; misaligned low bits are silently cleared.
  - Latch br_uncond.
  - pc holds; fetch_valid <= 0; busy <= 1; next state RESOLVE.
- RESOLVE, stall=1: hold; flag is not sampled.
- RESOLVE, stall=0: taken = latched_uncond | flag. The flag value is the one present in that cycle.
  - Taken:
    - pc <= latched target; flush <= 1; br_taken <= 1.
    - counter <= FLUSH_CYCLES-1; fetch_valid stays 0; next state FLUSH.
  - Not taken:
    - pc <= pc+4; fetch_valid <= 1; busy <= 0.
    - br_taken <= 0; next state FETCH.
- FLUSH:
  - stall is ignored.
  - flush and br_taken return to 0 after their single pulse cycle.
  - fetch_valid stays 0.
  - counter != 0: counter decrements.
  - counter == 0: fetch_valid <= 1; busy <= 0; next state FETCH. pc is unchanged; the first valid fetch is at the target.
- Latency:
  - Branch accept to resolution: 1 cycle, plus stall cycles.
  - Taken branch to first valid target fetch: 1 + FLUSH_CYCLES cycles after resolution.
- br_valid asserted in RESOLVE or FLUSH is ignored; upstream must observe busy.
- Unused state encodings recover to FETCH on the next edge with outputs as for FETCH/stall=0/br_valid=0.
- Reset mid-operation (any state) aborts the branch:
  - Registers take reset values on that edge.
  - No flush pulse is produced.
  - The latched target is discarded.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds outputs `taken_cnt` [15:0] and `nottaken_cnt` [15:0].
  - Each increments by one on its resolution edge and saturates at 16'hFFFF.
  - Both clear on rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then run, RESET_PC=0, no branches, stall=0 for 4 cycles -> pc 0,4,8,12; fetch_valid=1 from the first post-reset cycle.
- pc=0x10, br_valid=1, br_uncond=0, target=0x80, flag=0 in RESOLVE -> br_taken=0, flush=0, pc=0x14, busy low after 1 cycle.
- Same as above with flag=1, FLUSH_CYCLES=2 -> flush one pulse, br_taken one pulse, pc=0x80, fetch_valid low 3 cycles total, then high at 0x80.
- Unconditional branch, target=0x43, flag=0 -> taken, pc=0x40.
- Stall=1 for 3 cycles in RESOLVE while flag toggles, then stall=0 with flag=1 -> resolution uses only the final flag, taken.
- rst asserted in FLUSH; pc=0xFFFFFFFC non-branch increment -> reset values with no flush pulse; pc wraps to 0x00000000.
